// File: rtl/frame_concatenator_pkg.sv
// Shared state encoding, field widths and packed-parameter slicing helpers
// for the frame concatenator.
package frame_concatenator_pkg;

    localparam int RATIO_FW  = 8;
    localparam int LENGTH_FW = 16;
    localparam int MAX_CH    = 8;

    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    function automatic logic [RATIO_FW-1:0] get_ratio(
        input logic [RATIO_FW*MAX_CH-1:0] ratio_vec,
        input int                         c
    );
        return ratio_vec[c*RATIO_FW +: RATIO_FW];
    endfunction

    function automatic logic [LENGTH_FW-1:0] get_length(
        input logic [LENGTH_FW*MAX_CH-1:0] length_vec,
        input int                          c
    );
        return length_vec[c*LENGTH_FW +: LENGTH_FW];
    endfunction

endpackage

// File: rtl/frame_concatenator_serializer.sv
// Holds one input beat and walks it out LSB subword first; the current word
// is always the low OUT_WIDTH bits of the hold register.
module frame_concatenator_serializer
    import frame_concatenator_pkg::*;
#(
    parameter int IN_WIDTH  = 96,
    parameter int OUT_WIDTH = 8
) (
    input  logic                 clock_i,
    input  logic                 reset_i,
    input  logic                 load_i,
    input  logic                 shift_i,
    input  logic [IN_WIDTH-1:0]  lane_i,
    input  logic [RATIO_FW-1:0]  ratio_i,
    output logic [OUT_WIDTH-1:0] word_o,
    output logic                 last_next_o
);

    logic [IN_WIDTH-1:0] hold_q, hold_d;
    logic [RATIO_FW-1:0] sub_cnt_q, sub_cnt_d;
    logic [RATIO_FW-1:0] ratio_q, ratio_d;

    always_comb begin
        hold_d    = hold_q;
        sub_cnt_d = sub_cnt_q;
        ratio_d   = ratio_q;
        if (load_i) begin
            hold_d    = lane_i;
            sub_cnt_d = '0;
            ratio_d   = ratio_i;
        end else if (shift_i) begin
            hold_d    = hold_q >> OUT_WIDTH;
            sub_cnt_d = sub_cnt_q + RATIO_FW'(1);
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            hold_q    <= '0;
            sub_cnt_q <= '0;
            ratio_q   <= '0;
        end else begin
            hold_q    <= hold_d;
            sub_cnt_q <= sub_cnt_d;
            ratio_q   <= ratio_d;
        end
    end

    assign word_o = hold_q[OUT_WIDTH-1:0];
    // The next shift brings the beat's final subword into the output slot.
    assign last_next_o = (sub_cnt_q + RATIO_FW'(2)) == ratio_q;

endmodule

// File: rtl/frame_concatenator.sv
// N-channel frame concatenator: channel segments in order, serialised onto one
// valid/ready word stream. Define FRAME_CONCATENATOR_STATUS_EN for frame count / stall status.
module frame_concatenator
    import frame_concatenator_pkg::*;
#(
    parameter int                          NUM_CH    = 3,
    parameter int                          OUT_WIDTH = 8,
    parameter int                          IN_WIDTH  = 96,
    parameter logic [RATIO_FW*NUM_CH-1:0]  RATIO     = {8'd12, 8'd12, 8'd1},
    parameter logic [LENGTH_FW*NUM_CH-1:0] LENGTH    = {16'd132, 16'd12, 16'd144}
) (
    input  logic                       i_clock,
    input  logic                       i_reset,
    input  logic [NUM_CH*IN_WIDTH-1:0] i_in_data,
    input  logic [NUM_CH-1:0]          i_in_valid,
    output logic [NUM_CH-1:0]          o_in_ready,
    output logic [OUT_WIDTH-1:0]       o_out_data,
    output logic                       o_out_valid,
    output logic [$clog2(NUM_CH)-1:0]  o_out_chan,
    output logic                       o_out_first,
    output logic                       o_out_last,
`ifdef FRAME_CONCATENATOR_STATUS_EN
    output logic [15:0]                o_frame_count,
    output logic                       o_stall,
`endif
    input  logic                       i_out_ready
);

    localparam int CW = $clog2(NUM_CH);
    localparam logic [RATIO_FW*MAX_CH-1:0]  RATIO_X  = (RATIO_FW*MAX_CH)'(RATIO);
    localparam logic [LENGTH_FW*MAX_CH-1:0] LENGTH_X = (LENGTH_FW*MAX_CH)'(LENGTH);

    generate
        if (NUM_CH < 2 || NUM_CH > MAX_CH) begin : g_bad_num_ch
            $error("frame_concatenator: NUM_CH must be 2..8");
        end
        if (IN_WIDTH % OUT_WIDTH != 0) begin : g_bad_width
            $error("frame_concatenator: IN_WIDTH must be a multiple of OUT_WIDTH");
        end
        for (genvar c = 0; c < NUM_CH; c++) begin : g_chk
            localparam int R = int'(RATIO[c*RATIO_FW +: RATIO_FW]);
            localparam int L = int'(LENGTH[c*LENGTH_FW +: LENGTH_FW]);
            if (R == 0 || R*OUT_WIDTH > IN_WIDTH) begin : g_bad_ratio
                $error("frame_concatenator: illegal RATIO for a channel");
            end
            if (L == 0 || (R != 0 && (L % (R == 0 ? 1 : R)) != 0)) begin : g_bad_length
                $error("frame_concatenator: illegal LENGTH for a channel");
            end
        end
    endgenerate

    // chan_q/word_cnt_q name the position of the next word to be presented.
    state_t                 state_q;
    logic [CW-1:0]          chan_q;
    logic [LENGTH_FW-1:0]   word_cnt_q;
    logic                   run_q;
    logic                   out_valid_q;
    logic [CW-1:0]          out_chan_q;
    logic                   out_first_q;
    logic                   out_last_q;

    logic [RATIO_FW-1:0]    cur_ratio;
    logic [LENGTH_FW-1:0]   cur_len;
    logic [IN_WIDTH-1:0]    lane;
    logic                   slot_free;
    logic                   out_acc;
    logic                   load_en;
    logic                   shift_en;
    logic                   present;
    logic                   seg_end;
    logic                   chan_wrap;
    logic                   ser_last_next;

    assign cur_ratio = get_ratio(RATIO_X, int'(chan_q));
    assign cur_len   = get_length(LENGTH_X, int'(chan_q));
    assign lane      = i_in_data[int'(chan_q)*IN_WIDTH +: IN_WIDTH];

    assign slot_free = !out_valid_q || i_out_ready;
    assign out_acc   = out_valid_q && i_out_ready;
    assign load_en   = run_q && (state_q == ST_LOAD) && slot_free && i_in_valid[chan_q];
    assign shift_en  = (state_q == ST_SHIFT) && out_acc;
    assign present   = load_en || shift_en;
    assign seg_end   = word_cnt_q == (cur_len - LENGTH_FW'(1));
    assign chan_wrap = chan_q == CW'(NUM_CH - 1);

    always_comb begin
        o_in_ready = '0;
        if (run_q && state_q == ST_LOAD) begin
            o_in_ready[chan_q] = slot_free;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q     <= ST_LOAD;
            chan_q      <= '0;
            word_cnt_q  <= '0;
            run_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_first_q <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            run_q <= 1'b1;
            if (present) begin
                out_valid_q <= 1'b1;
                out_chan_q  <= chan_q;
                out_first_q <= (chan_q == '0) && (word_cnt_q == '0);
                out_last_q  <= chan_wrap && seg_end;
                if (seg_end) begin
                    word_cnt_q <= '0;
                    chan_q     <= chan_wrap ? '0 : chan_q + CW'(1);
                end else begin
                    word_cnt_q <= word_cnt_q + LENGTH_FW'(1);
                end
            end else if (out_acc) begin
                out_valid_q <= 1'b0;
            end

            if (load_en) begin
                state_q <= (cur_ratio == RATIO_FW'(1)) ? ST_LOAD : ST_SHIFT;
            end else if (shift_en && ser_last_next) begin
                // Final subword now presented: next beat may load as it is accepted.
                state_q <= ST_LOAD;
            end
        end
    end

    frame_concatenator_serializer #(
        .IN_WIDTH  (IN_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_serializer (
        .clock_i     (i_clock),
        .reset_i     (i_reset),
        .load_i      (load_en),
        .shift_i     (shift_en),
        .lane_i      (lane),
        .ratio_i     (cur_ratio),
        .word_o      (o_out_data),
        .last_next_o (ser_last_next)
    );

    assign o_out_valid = out_valid_q;
    assign o_out_chan  = out_chan_q;
    assign o_out_first = out_first_q;
    assign o_out_last  = out_last_q;

`ifdef FRAME_CONCATENATOR_STATUS_EN
    logic [15:0] frame_count_q;
    logic        stall_q;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            frame_count_q <= '0;
            stall_q       <= 1'b0;
        end else begin
            if (out_acc && out_last_q) begin
                frame_count_q <= frame_count_q + 16'd1;
            end
            stall_q <= out_valid_q && !i_out_ready;
        end
    end

    assign o_frame_count = frame_count_q;
    assign o_stall       = stall_q;
`endif

endmodule
